time_setter: RTL

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter.sv | 108 ++++++++++
 1 files changed

// File: rtl/time_setter.sv
// Time-of-day edit controller: captures the live time, lets the user adjust hours,
// minutes and seconds with wrap-around, then issues a one-cycle load strobe to the counter.
module time_setter (
  input  logic       clk_100MHz_i,
  input  logic       reset_ni,
  input  logic       mode_pulse_i,
  input  logic       inc_pulse_i,
  input  logic       dec_pulse_i,
  input  logic       cancel_pulse_i,
  input  logic [5:0] cur_seconds_i,
  input  logic [5:0] cur_minutes_i,
  input  logic [4:0] cur_hours_i,
  output logic [5:0] load_seconds_o,
  output logic [5:0] load_minutes_o,
  output logic [4:0] load_hours_o,
  output logic       load_time_o,
  output logic       count_enable_o,
  output logic [1:0] edit_field_o
);

  typedef enum logic [2:0] {RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  state_t     state_q, state_nxt;
  logic [5:0] sec_q, sec_nxt;
  logic [5:0] min_q, min_nxt;
  logic [4:0] hr_q, hr_nxt;
  logic       adj;

  // Modulo-60 step; anything at or above 59 wraps to 0 on increment.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
    if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // Both inc and dec in one cycle cancel each other out.
  assign adj = inc_pulse_i ^ dec_pulse_i;

  always_comb begin
    state_nxt = state_q;
    sec_nxt   = sec_q;
    min_nxt   = min_q;
    hr_nxt    = hr_q;
    case (state_q)
      RUN: begin
        if (mode_pulse_i) begin
          sec_nxt   = cur_seconds_i;
          min_nxt   = cur_minutes_i;
          hr_nxt    = cur_hours_i;
          state_nxt = EDIT_H;
        end
      end
      EDIT_H: begin
        if (cancel_pulse_i)    state_nxt = RUN;
        else if (mode_pulse_i) state_nxt = EDIT_M;
        else if (adj)          hr_nxt = step24(hr_q, inc_pulse_i);
      end
      EDIT_M: begin
        if (cancel_pulse_i)    state_nxt = RUN;
        else if (mode_pulse_i) state_nxt = EDIT_S;
        else if (adj)          min_nxt = step60(min_q, inc_pulse_i);
      end
      EDIT_S: begin
        if (cancel_pulse_i)    state_nxt = RUN;
        else if (mode_pulse_i) state_nxt = COMMIT;
        else if (adj)          sec_nxt = step60(sec_q, inc_pulse_i);
      end
      COMMIT:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RUN;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 5'd0;
    end else begin
      state_q <= state_nxt;
      sec_q   <= sec_nxt;
      min_q   <= min_nxt;
      hr_q    <= hr_nxt;
    end
  end

  // All outputs decode registered state only.
  assign load_seconds_o = sec_q;
  assign load_minutes_o = min_q;
  assign load_hours_o   = hr_q;
  assign load_time_o    = (state_q == COMMIT);
  assign count_enable_o = (state_q == RUN);

  always_comb begin
    edit_field_o = 2'd0;
    case (state_q)
      EDIT_H:  edit_field_o = 2'd1;
      EDIT_M:  edit_field_o = 2'd2;
      EDIT_S:  edit_field_o = 2'd3;
      default: edit_field_o = 2'd0;
    endcase
  end

endmodule
